// File: rtl/sig_change_tracer_if.sv
// Event stream port of the signal-change tracer: valid/ready handshake
// carrying {ts, mask, value} beats.
interface sig_change_tracer_if #(
  parameter int WIDTH = 8,
  parameter int TS_W  = 16
) ();
  logic                    ev_tvalid;
  logic                    ev_tready;
  logic [TS_W+2*WIDTH-1:0] ev_tdata;

  modport master (output ev_tvalid, output ev_tdata, input ev_tready);
  modport slave  (input ev_tvalid, input ev_tdata, output ev_tready);
endinterface

// File: rtl/sig_change_tracer.sv
// Multi-channel signal-change tracer: samples WIDTH channels each cycle and
// queues a timestamped {ts, mask, value} event whenever any channel changes.
module sig_change_tracer #(
  parameter int WIDTH = 8,
  parameter int TS_W  = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         sig_in,
  output logic [WIDTH-1:0]         sig_out,
  sig_change_tracer_if.master      ev,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_W + 2 * WIDTH;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask;
  logic             primed;
  logic [TS_W-1:0]  ts;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic push;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  assign sig_out = s_q;
  assign mask    = s_q ^ prev_q;
  assign push    = primed & en & (mask != '0);
  assign full    = (count == FULL_LVL);
  assign pop     = (count != '0) & ev.ev_tready;
  assign accept  = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign ev.ev_tvalid = (count != '0);
  assign ev.ev_tdata  = mem[rd_ptr];
  assign level        = count;

  // Priming loads prev_q from the value s_q takes on the same edge, so a
  // level held steady through reset compares equal on the first real edge.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      s_q    <= '0;
      prev_q <= '0;
      primed <= 1'b0;
      ts     <= '0;
    end else begin
      s_q <= sig_in;
      if (!primed) begin
        primed <= 1'b1;
        prev_q <= sig_in;
      end else begin
        prev_q <= s_q;
      end
      if (en) begin
        ts <= ts + TS_W'(1);
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while count != 0.
  always_ff @(posedge axis_clk) begin
    if (accept) begin
      mem[wr_ptr] <= {ts, mask, s_q};
    end
  end

  // A drop on the same edge as a clear restarts the count at one.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf) begin
        drop_cnt <= CNT_W'(1);
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sig_change_tracer.sv
// Scoreboard bench for sig_change_tracer: directed stimulus queues expected
// events, a negedge monitor pops and compares every accepted beat.
module tb_sig_change_tracer;

  localparam int WIDTH = 8;
  localparam int TS_W  = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int EW    = TS_W + 2 * WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [WIDTH-1:0]      sig_in;
  logic [WIDTH-1:0]      sig_out;
  logic [$clog2(DEPTH):0] level;
  logic                  overflow;
  logic [CNT_W-1:0]      drop_cnt;
  logic                  clr_ovf;

  int tests_run    = 0;
  int tests_failed = 0;
  int en_edges;
  int t0;
  logic [EW-1:0]    sb [$];
  logic [WIDTH-1:0] v;

  sig_change_tracer_if #(.WIDTH(WIDTH), .TS_W(TS_W)) ev_if ();

  sig_change_tracer #(
    .WIDTH(WIDTH), .TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .en         (en),
    .sig_in     (sig_in),
    .sig_out    (sig_out),
    .ev         (ev_if),
    .level      (level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  // Count of enabled edges since reset: the timestamp an event should carry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_edges <= 0;
    else if (en) en_edges <= en_edges + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] value);
    sig_in = value;
    step(1);
  endtask

  task automatic expect_event(input logic [TS_W-1:0] ts, input logic [WIDTH-1:0] mask,
                              input logic [WIDTH-1:0] value);
    sb.push_back({ts, mask, value});
  endtask

  initial begin : monitor
    logic [EW-1:0] exp_ev;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ev_if.ev_tvalid === 1'b1 && ev_if.ev_tready === 1'b1) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_event: got %0h expected no event", ev_if.ev_tdata);
        end else begin
          exp_ev = sb.pop_front();
          check_output("event", 32'(ev_if.ev_tdata), 32'(exp_ev));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    sig_in = 8'hFF;
    clr_ovf = 1'b0;
    ev_if.ev_tready = 1'b1;
    v = 8'hFF;
    step(2);
    check_output("rst_sig_out", 32'(sig_out), 32'h0);
    check_output("rst_tvalid", 32'(ev_if.ev_tvalid), 32'h0);
    check_output("rst_level", 32'(level), 32'h0);
    check_output("rst_overflow", 32'(overflow), 32'h0);
    check_output("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // Held nonzero level through reset: no event, sig_out follows one cycle later
    rst_n = 1'b1;
    step(1);
    check_output("t1_sig_out", 32'(sig_out), 32'hFF);
    for (int i = 0; i < 10; i++) begin
      check_output("t1_no_event", 32'(ev_if.ev_tvalid), 32'h0);
      step(1);
    end

    // Single changes and two-cycle latency
    apply_stimulus(8'h00);
    expect_event(en_edges[TS_W-1:0], 8'hFF, 8'h00);
    step(3);
    check_output("t2_drained", 32'(level), 32'h0);
    apply_stimulus(8'h05);
    check_output("t2_not_yet", 32'(ev_if.ev_tvalid), 32'h0);
    expect_event(en_edges[TS_W-1:0], 8'h05, 8'h05);
    step(1);
    check_output("t2_tvalid", 32'(ev_if.ev_tvalid), 32'h1);
    check_output("t2_level", 32'(level), 32'h1);
    step(1);
    check_output("t2_one_beat", 32'(ev_if.ev_tvalid), 32'h0);

    // Overfill with consumer stalled: 16 kept, 4 dropped
    ev_if.ev_tready = 1'b0;
    v = 8'h05;
    for (int i = 0; i < 20; i++) begin
      v ^= 8'h01;
      apply_stimulus(v);
      if (i < 16) expect_event(en_edges[TS_W-1:0], 8'h01, v);
    end
    step(1);
    check_output("t3_level", 32'(level), 32'd16);
    check_output("t3_overflow", 32'(overflow), 32'h1);
    check_output("t3_drop_cnt", 32'(drop_cnt), 32'd4);
    check_output("t3_head", 32'(ev_if.ev_tdata), 32'(sb[0]));

    // Full FIFO, pop coincident with push: accepted, no drop
    v ^= 8'h01;
    apply_stimulus(v);
    expect_event(en_edges[TS_W-1:0], 8'h01, v);
    ev_if.ev_tready = 1'b1;
    step(1);
    ev_if.ev_tready = 1'b0;
    check_output("t4_level", 32'(level), 32'd16);
    check_output("t4_drop_cnt", 32'(drop_cnt), 32'd4);
    ev_if.ev_tready = 1'b1;
    step(20);
    check_output("t4_drained", 32'(level), 32'h0);
    check_output("t4_sticky", 32'(overflow), 32'h1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check_output("clr_overflow", 32'(overflow), 32'h0);
    check_output("clr_drop_cnt", 32'(drop_cnt), 32'h0);

    // Disabled window: changes ignored, timestamp frozen
    t0 = en_edges;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sig_in = 8'hA0 + 8'(i);
      step(1);
    end
    en = 1'b1;
    step(3);
    check_output("t5_no_event", 32'(level), 32'h0);
    apply_stimulus(8'h55);
    expect_event(TS_W'(t0 + 4), 8'hF6, 8'h55);
    step(4);
    check_output("t5_drained", 32'(level), 32'h0);

    // Reset mid-operation discards queued events
    ev_if.ev_tready = 1'b0;
    v = 8'h55;
    for (int i = 0; i < 3; i++) begin
      v ^= 8'h01;
      apply_stimulus(v);
      expect_event(en_edges[TS_W-1:0], 8'h01, v);
    end
    step(1);
    check_output("t6_level_pre", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_level", 32'(level), 32'h0);
    check_output("t6_rst_tvalid", 32'(ev_if.ev_tvalid), 32'h0);
    sb.delete();
    sig_in = 8'h3C;
    step(2);
    rst_n = 1'b1;
    ev_if.ev_tready = 1'b1;

    // Timestamp wrap: change lands in s_q at edge 18, pushed with ts 18 mod 16
    step(17);
    apply_stimulus(8'h3D);
    expect_event(4'd2, 8'h01, 8'h3D);
    step(3);
    check_output("t6_drained", 32'(level), 32'h0);

    // Clear coincident with a drop
    ev_if.ev_tready = 1'b0;
    v = 8'h3D;
    for (int i = 0; i < 18; i++) begin
      v ^= 8'h01;
      apply_stimulus(v);
      if (i < 16) expect_event(en_edges[TS_W-1:0], 8'h01, v);
    end
    step(1);
    check_output("t7_drop_cnt", 32'(drop_cnt), 32'd2);
    check_output("t7_level", 32'(level), 32'd16);
    v ^= 8'h01;
    apply_stimulus(v);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check_output("t7_clr_drop_ovf", 32'(overflow), 32'h1);
    check_output("t7_clr_drop_cnt", 32'(drop_cnt), 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check_output("t7_clr_ovf", 32'(overflow), 32'h0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) begin
      v ^= 8'h01;
      apply_stimulus(v);
    end
    step(1);
    check_output("t8_saturate", 32'(drop_cnt), 32'hFF);
    check_output("t8_overflow", 32'(overflow), 32'h1);
    ev_if.ev_tready = 1'b1;
    step(20);
    check_output("t8_drained", 32'(level), 32'h0);
    check_output("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
